// File: rtl/ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rr_arbiter
//
// Round-robin arbiter and sequencer that shares one 2^AW x DW RAM between
// two clients, A and B. The RAM has an asynchronous read and a synchronous
// write. Each grant performs exactly one RAM operation. The winning client
// then receives a registered one-cycle ack and, for reads, registered read
// data.
//
// Handshake: a client raises req together with a stable we/addr/wdata and
// holds all of them until its ack pulse. In the ack cycle that client is
// not eligible, so the stale req is ignored. If req is still high in the
// cycle after ack, it is taken as a new request.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   a_req/a_we/a_addr/a_wdata   client A request, op, address, write data
//   a_ack, a_rdata              client A completion pulse and read data
//   b_*                         same set for client B
//   ram_wr_en/ram_wr_addr/
//   ram_wr_data/ram_rd_addr     drive the RAM
//   ram_rd_data                 combinational read data from the RAM
//   busy                        high while the single BUSY cycle is active
//
// Optional feature (macro RAM_RR_ARBITER_STATS_EN):
//   a_cnt, b_cnt                saturating 8-bit grant counters per client
// ---------------------------------------------------------------------------
module ram_rr_arbiter #(
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          ram_wr_en,
   output logic [AW-1:0] ram_wr_addr,
   output logic [DW-1:0] ram_wr_data,
   output logic [AW-1:0] ram_rd_addr,
   input  logic [DW-1:0] ram_rd_data,
   output logic          busy
`ifdef RAM_RR_ARBITER_STATS_EN
   ,
   output logic [7:0]    a_cnt,
   output logic [7:0]    b_cnt
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Client id encoding for r_id and r_last_grant.
   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   state_t        r_state;
   state_t        w_next_state;

   logic          r_last_grant;
   logic          r_id;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   logic          r_a_ack;
   logic          r_b_ack;
   logic [DW-1:0] r_a_rdata;
   logic [DW-1:0] r_b_rdata;

   logic          w_elig_a;
   logic          w_elig_b;
   logic          w_grant_a;
   logic          w_grant_b;
   logic          w_grant;

   // A client is not eligible while its own ack is high. At that point its
   // req is the stale one from the access that has just completed.
   assign w_elig_a = a_req && !r_a_ack;
   assign w_elig_b = b_req && !r_b_ack;
   assign w_grant  = w_grant_a || w_grant_b;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and grant decision
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_grant_a    = 1'b0;
      w_grant_b    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // On a tie, the client that did not win last time gets the grant.
            if (w_elig_a && (!w_elig_b || r_last_grant == ID_B)) begin
               w_grant_a = 1'b1;
            end else if (w_elig_b) begin
               w_grant_b = 1'b1;
            end
            if (w_grant_a || w_grant_b) begin
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Latched operation fields, captured on the grant edge
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= ID_B;
         r_id         <= ID_A;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else if (w_grant) begin
         r_last_grant <= w_grant_b;
         r_id         <= w_grant_b;
         r_we         <= w_grant_b ? b_we    : a_we;
         r_addr       <= w_grant_b ? b_addr  : a_addr;
         r_wdata      <= w_grant_b ? b_wdata : a_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Completion: ack and read data registered at the edge that ends BUSY
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_ack   <= 1'b0;
         r_b_ack   <= 1'b0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_a_ack <= (r_state == ST_BUSY) && (r_id == ID_A);
         r_b_ack <= (r_state == ST_BUSY) && (r_id == ID_B);
         if ((r_state == ST_BUSY) && !r_we) begin
            if (r_id == ID_A) begin
               r_a_rdata <= ram_rd_data;
            end else begin
               r_b_rdata <= ram_rd_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // RAM drive. Address and data simply follow the latched fields, so they
   // keep their last values outside BUSY. The write enable is qualified by
   // the state.
   // ---------------------------------------------------------------------
   assign ram_wr_en   = (r_state == ST_BUSY) && r_we;
   assign ram_wr_addr = r_addr;
   assign ram_rd_addr = r_addr;
   assign ram_wr_data = r_wdata;

   assign busy    = (r_state == ST_BUSY);
   assign a_ack   = r_a_ack;
   assign b_ack   = r_b_ack;
   assign a_rdata = r_a_rdata;
   assign b_rdata = r_b_rdata;

`ifdef RAM_RR_ARBITER_STATS_EN
   // ---------------------------------------------------------------------
   // Grant counters. They saturate at 255 and count on the IDLE->BUSY edge.
   // ---------------------------------------------------------------------
   logic [7:0] r_a_cnt;
   logic [7:0] r_b_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_cnt <= '0;
         r_b_cnt <= '0;
      end else begin
         if (w_grant_a && (r_a_cnt != 8'hFF)) begin
            r_a_cnt <= r_a_cnt + 8'd1;
         end
         if (w_grant_b && (r_b_cnt != 8'hFF)) begin
            r_b_cnt <= r_b_cnt + 8'd1;
         end
      end
   end

   assign a_cnt = r_a_cnt;
   assign b_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_rr_arbiter
//
// Directed bench for ram_rr_arbiter. A behavioural 8x16 RAM is attached to
// the RAM ports (async read, sync write). The bench also has a side preload
// port into that RAM. Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
// Expected values are worked out by hand from the arbiter behaviour:
//   req seen at edge N -> busy in cycle N+1 -> ack in cycle N+2.
// ---------------------------------------------------------------------------
module tb_ram_rr_arbiter;

   localparam int AW = 3;
   localparam int DW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          a_req = 1'b0, a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          a_ack;
   logic [DW-1:0] a_rdata;
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic          b_ack;
   logic [DW-1:0] b_rdata;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic          busy;
`ifdef RAM_RR_ARBITER_STATS_EN
   logic [7:0]    a_cnt;
   logic [7:0]    b_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_req       (a_req),
      .a_we        (a_we),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_ack       (a_ack),
      .a_rdata     (a_rdata),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_ack       (b_ack),
      .b_rdata     (b_rdata),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .busy        (busy)
`ifdef RAM_RR_ARBITER_STATS_EN
      ,
      .a_cnt       (a_cnt),
      .b_cnt       (b_cnt)
`endif
   );

   // ---------------- behavioural RAM ----------------
   logic [DW-1:0] mem [0:7];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end
   assign ram_rd_data = mem[ram_rd_addr];

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = addr; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      // Reset is held from time 0.
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0 || ram_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: a_ack=%b b_ack=%b busy=%b wr_en=%b, want all 0",
                  a_ack, b_ack, busy, ram_wr_en);
      end
      n_checks++;
      if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_rdata: a_rdata=%h b_rdata=%h, want 0000/0000", a_rdata, b_rdata);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) preload(i[AW-1:0], 16'h0000);
      preload(3'd0, 16'h1234);

      // Start a write from A, then assert reset mid-BUSY.
      @(negedge clk);
      drive_a(1'b1, 1'b1, 3'd3, 16'h5555);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || ram_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_busy: busy=%b wr_en=%b, want 1/1", busy, ram_wr_en);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || ram_wr_en !== 1'b0 || a_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b wr_en=%b a_ack=%b, want 0/0/0",
                  busy, ram_wr_en, a_ack);
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL aborted_no_ack: a_ack=%b, want 0", a_ack);
      end
      rst = 1'b0;

      // After release, the first tie goes to A. Both clients read addr 0.
      drive_a(1'b1, 1'b0, 3'd0, 16'h0000);
      drive_b(1'b1, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || ram_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_busy: busy=%b wr_en=%b, want 1/0", busy, ram_wr_en);
      end
      drive_b(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL tie_first_a: a_ack=%b b_ack=%b a_rdata=%h, want 1/0/1234",
                  a_ack, b_ack, a_rdata);
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
   endtask

   task automatic test_write_read;
      drive_a(1'b1, 1'b1, 3'd5, 16'hBEEF);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || ram_wr_en !== 1'b1 || ram_wr_addr !== 3'd5 ||
          ram_rd_addr !== 3'd5 || ram_wr_data !== 16'hBEEF || a_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL write_busy: busy=%b wr_en=%b wa=%0d ra=%0d wd=%h a_ack=%b, want 1/1/5/5/BEEF/0",
                  busy, ram_wr_en, ram_wr_addr, ram_rd_addr, ram_wr_data, a_ack);
      end
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b1 || ram_wr_en !== 1'b0 || busy !== 1'b0 || a_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL write_ack: a_ack=%b wr_en=%b busy=%b a_rdata=%h, want 1/0/0/1234",
                  a_ack, ram_wr_en, busy, a_rdata);
      end
      n_checks++;
      if (ram_wr_addr !== 3'd5 || ram_wr_data !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL ram_hold: wa=%0d wd=%h, want 5/BEEF", ram_wr_addr, ram_wr_data);
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      drive_b(1'b1, 1'b0, 3'd5, 16'h0000);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || ram_wr_en !== 1'b0 || ram_rd_addr !== 3'd5) begin
         n_fail++;
         $display("FAIL read_busy: busy=%b wr_en=%b ra=%0d, want 1/0/5", busy, ram_wr_en, ram_rd_addr);
      end
      @(negedge clk);
      n_checks++;
      if (b_ack !== 1'b1 || a_ack !== 1'b0 || b_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL read_after_write: b_ack=%b a_ack=%b b_rdata=%h, want 1/0/BEEF",
                  b_ack, a_ack, b_rdata);
      end
      drive_b(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
   endtask

   task automatic test_alternate;
      logic exp_a, exp_b;
      preload(3'd1, 16'h0011);
      preload(3'd2, 16'h0022);
      // B won last, so A goes first.
      drive_a(1'b1, 1'b0, 3'd1, 16'h0000);
      drive_b(1'b1, 1'b0, 3'd2, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_a = (i % 4 == 2);
         exp_b = (i % 4 == 0);
         n_checks++;
         if (a_ack !== exp_a || b_ack !== exp_b) begin
            n_fail++;
            $display("FAIL alternate_ack[%0d]: a_ack=%b b_ack=%b, want %b/%b",
                     i, a_ack, b_ack, exp_a, exp_b);
         end
         if (exp_a) begin
            n_checks++;
            if (a_rdata !== 16'h0011) begin
               n_fail++;
               $display("FAIL alternate_a_rdata[%0d]: got %h, want 0011", i, a_rdata);
            end
         end
         if (exp_b) begin
            n_checks++;
            if (b_rdata !== 16'h0022) begin
               n_fail++;
               $display("FAIL alternate_b_rdata[%0d]: got %h, want 0022", i, b_rdata);
            end
         end
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      drive_b(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_hold_extra;
      int acks;
      // Case 1: req is held only through the ack cycle, giving one access.
      acks = 0;
      drive_a(1'b1, 1'b0, 3'd1, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (a_ack === 1'b1) acks++;
         if (i == 3) drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      end
      n_checks++;
      if (acks != 1) begin
         n_fail++;
         $display("FAIL hold_through_ack: acks=%0d, want 1", acks);
      end
      // Case 2: req is held one cycle past the ack, giving a second access.
      acks = 0;
      drive_a(1'b1, 1'b0, 3'd1, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (a_ack === 1'b1) acks++;
         if (i == 4) drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      end
      n_checks++;
      if (acks != 2) begin
         n_fail++;
         $display("FAIL hold_extra_cycle: acks=%0d, want 2", acks);
      end
   endtask

   task automatic test_back_to_back;
      int acks;
      int b_seen;
      acks = 0;
      b_seen = 0;
      // A alone holds req. A is not blocked by last_grant=A. Each access
      // takes grant, BUSY, then the ack cycle in which req is ignored, so
      // grants land at edges 1, 4, 7 and 10 and acks at negedges 2, 5, 8
      // and 11.
      drive_a(1'b1, 1'b0, 3'd2, 16'h0000);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (a_ack === 1'b1) acks++;
         if (b_ack === 1'b1) b_seen++;
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      n_checks++;
      if (acks != 4 || b_seen != 0) begin
         n_fail++;
         $display("FAIL back_to_back: a_acks=%0d b_acks=%0d, want 4/0", acks, b_seen);
      end
      n_checks++;
      if (a_rdata !== 16'h0022) begin
         n_fail++;
         $display("FAIL back_to_back_rdata: got %h, want 0022", a_rdata);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

`ifdef RAM_RR_ARBITER_STATS_EN
   task automatic test_stats;
      int acks;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acks = 0;
      drive_a(1'b1, 1'b0, 3'd0, 16'h0000);
      while (acks < 300) begin
         @(negedge clk);
         if (a_ack === 1'b1) acks++;
      end
      drive_a(1'b0, 1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (a_cnt !== 8'd255 || b_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL stats_saturate: a_cnt=%0d b_cnt=%0d, want 255/0", a_cnt, b_cnt);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL stats_reset: a_cnt=%0d b_cnt=%0d, want 0/0", a_cnt, b_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask
`endif

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- sequence and report ----------------
   initial begin
      test_reset;
      test_write_read;
      test_alternate;
      test_hold_extra;
      test_back_to_back;
`ifdef RAM_RR_ARBITER_STATS_EN
      test_stats;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
